pc: RTL and testbench

PC -- requirements
Module: pc

---
 rtl/pc.sv | 40 ++++
 tb/tb_pc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc.sv
// Program counter register.
// Holds the current fetch address and loads the externally computed next-PC
// on every rising clock edge. An optional alignment mask clears the byte
// offset bits of each loaded address. Reset is asynchronous and active-low
// and returns the counter to RESET_PC without waiting for a clock edge.
module pc #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter bit          FORCE_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  output logic [31:0] out_pc
);

  // Mask applied to every loaded address; RESET_PC bypasses it, so it must
  // already be word-aligned.
  localparam logic [31:0] ALIGN_MASK = FORCE_ALIGN ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Next value is the incoming address with the optional alignment mask only;
  // no increment or other arithmetic happens here.
  always_comb begin
    pc_d = in_pc & ALIGN_MASK;
  end

  // Edge-triggered load; reset forces RESET_PC immediately and holds it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out_pc = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for the program counter register.
// Two instances run side by side, one with alignment enabled and one without,
// so every vector checks both behaviours. Expected values come from a table
// and travel through a scoreboard queue from drive time to the capturing edge.
module tb_pc;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] out_a;
  logic [31:0] out_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] in_v;
    logic [31:0] exp_a;
    logic [31:0] exp_n;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp_a;
    logic [31:0] exp_n;
    string       name;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  pc u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .in_pc  (in_pc),
    .out_pc (out_a)
  );

  pc #(.FORCE_ALIGN(1'b0)) u_dut_n (
    .clk    (clk),
    .reset  (reset),
    .in_pc  (in_pc),
    .out_pc (out_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare both instances against it.
  task automatic pop_and_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_align"}, out_a, e.exp_a);
      check({e.name, "_noalign"}, out_n, e.exp_n);
      $display("txn %s in=%h out_align=%h out_noalign=%h", e.name, in_pc, out_a, out_n);
    end
  endtask

  // Drive one vector just after a falling edge, confirm nothing moves before
  // the rising edge, then compare after it.
  task automatic apply(input logic [31:0] v, input logic [31:0] ea,
                       input logic [31:0] en, input string name);
    logic [31:0] prev_a;
    logic [31:0] prev_n;
    prev_a = out_a;
    prev_n = out_n;
    in_pc  = v;
    sb_q.push_back('{ea, en, name});
    #1;
    check({name, "_pre_align"}, out_a, prev_a);
    check({name, "_pre_noalign"}, out_n, prev_n);
    @(posedge clk);
    #1;
    pop_and_check();
    @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_3007, 32'h0000_3004, 32'h0000_3007, "unaligned_3007"};
    vecs[1] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, "low_bit"};
    vecs[2] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0002, "msb_set"};
    vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "wrap_top"};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "wrap_zero"};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, "all_ones"};
    vecs[6] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_5679, "pattern"};
    vecs[7] = '{32'h0000_3004, 32'h0000_3004, 32'h0000_3004, "stable_1"};
    vecs[8] = '{32'h0000_3004, 32'h0000_3004, 32'h0000_3004, "stable_2"};
    vecs[9] = '{32'h0000_4000, 32'h0000_4000, 32'h0000_4000, "load_4000"};

    // Reset held low from time zero for 100 ns while in_pc moves around.
    reset = 1'b0;
    in_pc = 32'h0000_1234;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("reset_hold_align", out_a, 32'h0000_3000);
      check("reset_hold_noalign", out_n, 32'h0000_3000);
      if (i == 10) in_pc = 32'hFFFF_FFFF;
      #4;
    end

    // Release at t=100 (falling clk edge); first rising edge loads in_pc.
    reset = 1'b1;
    in_pc = 32'h0000_3004;
    sb_q.push_back('{32'h0000_3004, 32'h0000_3004, "first_load"});
    #1;
    check("first_load_pre_align", out_a, 32'h0000_3000);
    check("first_load_pre_noalign", out_n, 32'h0000_3000);
    @(posedge clk);
    #1;
    pop_and_check();
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].in_v, vecs[i].exp_a, vecs[i].exp_n, vecs[i].name);
    end

    // Mid-cycle reset: out_pc must drop to RESET_PC before the next edge.
    check("pre_reset_state", out_a, 32'h0000_4000);
    reset = 1'b0;
    #1;
    check("async_reset_align", out_a, 32'h0000_3000);
    check("async_reset_noalign", out_n, 32'h0000_3000);
    in_pc = 32'h7777_0003;
    @(posedge clk);
    #1;
    check("reset_edge_hold_align", out_a, 32'h0000_3000);
    check("reset_edge_hold_noalign", out_n, 32'h0000_3000);
    $display("txn reset_mid_cycle in=%h out_align=%h out_noalign=%h", in_pc, out_a, out_n);
    @(negedge clk);

    // Release again between edges; next rising edge loads.
    reset = 1'b1;
    apply(32'h0000_300B, 32'h0000_3008, 32'h0000_300B, "post_reset_load");

    // in_pc glitches between edges; only the settled value is captured.
    in_pc = 32'h0000_5000;
    sb_q.push_back('{32'h0000_5000, 32'h0000_5000, "toggle_settle"});
    #1;
    check("toggle_a_align", out_a, 32'h0000_3008);
    in_pc = 32'h0000_6000;
    #1;
    check("toggle_b_align", out_a, 32'h0000_3008);
    check("toggle_b_noalign", out_n, 32'h0000_300B);
    in_pc = 32'h0000_5000;
    #1;
    check("toggle_c_align", out_a, 32'h0000_3008);
    @(posedge clk);
    #1;
    pop_and_check();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
